mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-requester arbiter for the single 8-bit memory port. It sits between the Cpu core (requester 0) and a second bus master (requester 1, a debug loader or DMA engine). It serialises `req_rdwr`-style requests onto one registered memory interface, applies round-robin on ties and returns read data with a one-cycle acknowledge. The requester-side signals use the same request/direction/address/data convention as the Cpu outputs, so the Cpu connects directly as requester 0.

## Interface
Parameters:
- `ADDR_WIDTH`, default 16: address width; matches the Cpu's 16-bit actual address space.
- `DATA_WIDTH`, default 8: data width.

Ports:
- `clk`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  reset; one clock, reset is synchronous and active-high.
- `r0_req_rdwr`  in  1  requester 0 access request (level).
- `r0_which_rdwr`  in  1  requester 0 direction: `ENUM__CPU_WH_RDWR__READ` / `ENUM__CPU_WH_RDWR__WRITE`.
- `r0_addr`  in  ADDR_WIDTH  requester 0 address.
- `r0_data_out`  in  DATA_WIDTH  requester 0 write data.
- `r0_data_in`  out  DATA_WIDTH  last read data returned to requester 0.
- `r0_ack`  out  1  one-cycle pulse: requester 0 transaction complete.
- `r1_req_rdwr`, `r1_which_rdwr`, `r1_addr`, `r1_data_out`, `r1_data_in`, `r1_ack`: same as requester 0, for requester 1.
- `mem_req_rdwr`  out  1  memory request.
- `mem_which_rdwr`  out  1  memory direction.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_data_out`  out  DATA_WIDTH  memory write data.
- `mem_data_in`  in  DATA_WIDTH  memory read data, valid the cycle after `mem_req_rdwr` is high.

## Operation
- All outputs are registered.
- State machine: IDLE → ACCESS → WAIT → DONE → IDLE.
- **IDLE:** requests are sampled here only.
  - If no request is present, stay in IDLE.
  - If only one requester has its request high, it wins.
  - If both are high, the requester that is not `last_grant` wins.
  - On a grant, latch `owner` and the winner's direction, address and write data into the `mem_*` outputs, set `mem_req_rdwr`=1 and go to ACCESS.
- **ACCESS:** `mem_req_rdwr` is high for exactly this cycle. On the closing edge, clear `mem_req_rdwr` and go to WAIT. `mem_addr`, `mem_which_rdwr` and `mem_data_out` hold their values.
- **WAIT:** `mem_data_in` is valid during this cycle. On the closing edge:
  - For a read, capture `mem_data_in` into `r<owner>_data_in`.
  - Set `r<owner>_ack`=1, set `last_grant`=`owner` and go to DONE.
- **DONE:** the ack is visible for this single cycle. On the closing edge, clear the ack and go to IDLE.
- Requester-side input changes during ACCESS, WAIT and DONE are ignored; the transaction uses only the values latched in IDLE.
- A request still high when IDLE is re-entered counts as a new request. The requester must drop `req_rdwr` during its ack cycle if it wants only one transaction.
- A write never modifies `rN_data_in`. Each `rN_data_in` holds its value until that requester's next read completes.
- A request withdrawn before it is granted produces no memory cycle and no ack.
- Reset values: `mem_req_rdwr`=0, `mem_which_rdwr`=READ, `mem_addr`=0, `mem_data_out`=0, `r0_data_in`=`r1_data_in`=0, `r0_ack`=`r1_ack`=0, state=IDLE, `last_grant`=1, so requester 0 wins the first tie.
- Reset mid-transaction (any state): the next edge restores all reset values. The in-flight access is abandoned, no ack is issued and read data is not captured.

## Timing
- Edge E0: a request is sampled in IDLE.
- Cycle after E0: ACCESS; `mem_req_rdwr`=1 with address, direction and data.
- Cycle after E1: WAIT; `mem_data_in` is valid.
- Cycle after E2: DONE; `rN_ack`=1 and `rN_data_in` is updated.
- E3: return to IDLE. The earliest next grant is sampled at E4.
- Request-to-ack latency: 3 clocks. Peak throughput: one transaction per 4 clocks.
- `mem_req_rdwr` is never high in two consecutive cycles.
- At most one ack is high in any cycle. An ack is never high in the same cycle as `mem_req_rdwr`.
- With both requests held continuously, grants alternate 0,1,0,1… at 4-clock spacing.

## Test plan
- **Single read:** memory holds 0x45 at 0xf000; after reset, r0 reads 0xf000 → `mem_req_rdwr` is high for 1 cycle with `mem_addr`=0xf000 and READ; `r0_ack` pulses 3 clocks after sampling; `r0_data_in`=0x45.
- **Single write:** r1 writes 0x87 to 0xf500 → one memory cycle with WRITE, `mem_addr`=0xf500 and `mem_data_out`=0x87; `r1_ack` pulses; `r1_data_in` is unchanged; a subsequent read of 0xf500 by r0 returns 0x87.
- **Tie after reset:** both request in the same cycle → r0 is granted first and r1 is served 4 clocks later. With both held for 4 transactions, the grant order is 0,1,0,1 and no ack overlaps another.
- **Latched inputs:** r0 changes `r0_addr` from 0xf000 to 0x1234 during ACCESS → `mem_addr` stays 0xf000 through WAIT; the ack still goes to r0.
- **Reset in WAIT:** `rst` is asserted during WAIT → the next cycle shows all reset values, no ack and `r0_data_in`=0. A following tie is granted to r0.
- **No request:** all requests stay low for 20 clocks → `mem_req_rdwr`, `r0_ack` and `r1_ack` stay 0 and the state remains IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter onto one registered memory port.
// Latency: request sampled at E0, mem_req_rdwr the next cycle, ack 3 clocks after sampling.
// Backpressure: a requester holds req_rdwr until its one-cycle ack; one transaction per 4 clocks.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r0_req_rdwr,
    input  logic                  r0_which_rdwr,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_data_out,
    output logic [DATA_WIDTH-1:0] r0_data_in,
    output logic                  r0_ack,
    input  logic                  r1_req_rdwr,
    input  logic                  r1_which_rdwr,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_data_out,
    output logic [DATA_WIDTH-1:0] r1_data_in,
    output logic                  r1_ack,
    output logic                  mem_req_rdwr,
    output logic                  mem_which_rdwr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic [DATA_WIDTH-1:0] mem_data_in
);

    localparam logic ENUM__CPU_WH_RDWR__READ  = 1'b0;
    localparam logic ENUM__CPU_WH_RDWR__WRITE = 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

    typedef struct packed {
        logic                  which;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] dat;
    } req_t;

    state_t                state, state_nxt;
    logic                  owner, owner_nxt;
    logic                  last_grant, last_grant_nxt;
    logic                  winner;
    req_t                  mem_q, mem_nxt, win_req;
    logic                  mem_req_nxt;
    logic                  r0_ack_nxt, r1_ack_nxt;
    logic [DATA_WIDTH-1:0] r0_data_nxt, r1_data_nxt;

    // On a tie the requester that was not served last wins.
    assign winner  = r1_req_rdwr & (~r0_req_rdwr | ~last_grant);
    assign win_req = winner ? '{r1_which_rdwr, r1_addr, r1_data_out}
                            : '{r0_which_rdwr, r0_addr, r0_data_out};

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        mem_nxt        = mem_q;
        mem_req_nxt    = 1'b0;
        r0_ack_nxt     = 1'b0;
        r1_ack_nxt     = 1'b0;
        r0_data_nxt    = r0_data_in;
        r1_data_nxt    = r1_data_in;
        case (state)
            S_IDLE: begin
                if (r0_req_rdwr || r1_req_rdwr) begin
                    owner_nxt   = winner;
                    mem_nxt     = win_req;
                    mem_req_nxt = 1'b1;
                    state_nxt   = S_ACCESS;
                end
            end
            S_ACCESS: state_nxt = S_WAIT;
            S_WAIT: begin
                if (owner) begin
                    r1_ack_nxt = 1'b1;
                    if (mem_q.which == ENUM__CPU_WH_RDWR__READ) r1_data_nxt = mem_data_in;
                end else begin
                    r0_ack_nxt = 1'b1;
                    if (mem_q.which == ENUM__CPU_WH_RDWR__READ) r0_data_nxt = mem_data_in;
                end
                last_grant_nxt = owner;
                state_nxt      = S_DONE;
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            mem_q        <= '{ENUM__CPU_WH_RDWR__READ, '0, '0};
            mem_req_rdwr <= 1'b0;
            r0_ack       <= 1'b0;
            r1_ack       <= 1'b0;
            r0_data_in   <= '0;
            r1_data_in   <= '0;
        end else begin
            state        <= state_nxt;
            owner        <= owner_nxt;
            last_grant   <= last_grant_nxt;
            mem_q        <= mem_nxt;
            mem_req_rdwr <= mem_req_nxt;
            r0_ack       <= r0_ack_nxt;
            r1_ack       <= r1_ack_nxt;
            r0_data_in   <= r0_data_nxt;
            r1_data_in   <= r1_data_nxt;
        end
    end

    assign mem_which_rdwr = mem_q.which;
    assign mem_addr       = mem_q.addr;
    assign mem_data_out   = mem_q.dat;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a one-cycle-latency memory model.
module tb_mem_bus_arbiter;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req_rdwr, r0_which_rdwr, r1_req_rdwr, r1_which_rdwr;
    logic [15:0] r0_addr, r1_addr;
    logic [7:0]  r0_data_out, r1_data_out, r0_data_in, r1_data_in;
    logic        r0_ack, r1_ack;
    logic        mem_req_rdwr, mem_which_rdwr;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_out;
    logic [7:0]  mem_data_in = 8'h00;
    logic [7:0]  mem [0:65535];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .r0_req_rdwr(r0_req_rdwr), .r0_which_rdwr(r0_which_rdwr), .r0_addr(r0_addr),
        .r0_data_out(r0_data_out), .r0_data_in(r0_data_in), .r0_ack(r0_ack),
        .r1_req_rdwr(r1_req_rdwr), .r1_which_rdwr(r1_which_rdwr), .r1_addr(r1_addr),
        .r1_data_out(r1_data_out), .r1_data_in(r1_data_in), .r1_ack(r1_ack),
        .mem_req_rdwr(mem_req_rdwr), .mem_which_rdwr(mem_which_rdwr), .mem_addr(mem_addr),
        .mem_data_out(mem_data_out), .mem_data_in(mem_data_in)
    );

    // Memory returns the old contents the cycle after the request; writes land on the same edge.
    always @(posedge clk) begin
        if (mem_req_rdwr) begin
            mem_data_in <= mem[mem_addr];
            if (mem_which_rdwr == WR) mem[mem_addr] <= mem_data_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        mem[16'hf000] = 8'h45;
        mem[16'hf500] = 8'h5a;
        mem[16'h0010] = 8'h11;
        mem[16'h0020] = 8'h22;
        rst = 1'b1;
        r0_req_rdwr = 1'b0; r0_which_rdwr = RD; r0_addr = 16'h0; r0_data_out = 8'h0;
        r1_req_rdwr = 1'b0; r1_which_rdwr = RD; r1_addr = 16'h0; r1_data_out = 8'h0;
        step(); step();
        chk("rst_mem_req", {31'b0, mem_req_rdwr}, 32'd0);
        chk("rst_mem_which", {31'b0, mem_which_rdwr}, {31'b0, RD});
        chk("rst_mem_addr", {16'b0, mem_addr}, 32'h0);
        chk("rst_acks", {30'b0, r1_ack, r0_ack}, 32'd0);
        chk("rst_data_in", {16'b0, r1_data_in, r0_data_in}, 32'h0);
        rst = 1'b0;

        // Single read by r0
        r0_req_rdwr = 1'b1; r0_which_rdwr = RD; r0_addr = 16'hf000;
        step();
        r0_req_rdwr = 1'b0;
        chk("rd_mem_req", {31'b0, mem_req_rdwr}, 32'd1);
        chk("rd_mem_addr", {16'b0, mem_addr}, 32'hf000);
        chk("rd_mem_which", {31'b0, mem_which_rdwr}, {31'b0, RD});
        step();
        chk("rd_wait_req", {31'b0, mem_req_rdwr}, 32'd0);
        chk("rd_wait_ack", {31'b0, r0_ack}, 32'd0);
        step();
        chk("rd_ack", {30'b0, r1_ack, r0_ack}, 32'd1);
        chk("rd_data", {24'b0, r0_data_in}, 32'h45);
        step();
        chk("rd_ack_clear", {30'b0, r1_ack, r0_ack}, 32'd0);

        // Single write by r1, then r0 reads it back
        r1_req_rdwr = 1'b1; r1_which_rdwr = WR; r1_addr = 16'hf500; r1_data_out = 8'h87;
        step();
        r1_req_rdwr = 1'b0;
        chk("wr_mem_req", {31'b0, mem_req_rdwr}, 32'd1);
        chk("wr_mem_which", {31'b0, mem_which_rdwr}, {31'b0, WR});
        chk("wr_mem_addr", {16'b0, mem_addr}, 32'hf500);
        chk("wr_mem_data", {24'b0, mem_data_out}, 32'h87);
        step(); step();
        chk("wr_ack", {30'b0, r1_ack, r0_ack}, 32'd2);
        chk("wr_r1_data_kept", {24'b0, r1_data_in}, 32'h00);
        step();
        r0_req_rdwr = 1'b1; r0_which_rdwr = RD; r0_addr = 16'hf500;
        step();
        r0_req_rdwr = 1'b0;
        chk("wrrd_mem_addr", {16'b0, mem_addr}, 32'hf500);
        step(); step();
        chk("wrrd_ack", {30'b0, r1_ack, r0_ack}, 32'd1);
        chk("wrrd_data", {24'b0, r0_data_in}, 32'h87);
        step();

        // Tie after reset: alternating grants 0,1,0,1
        rst = 1'b1; step(); rst = 1'b0;
        r0_req_rdwr = 1'b1; r0_which_rdwr = RD; r0_addr = 16'h0010;
        r1_req_rdwr = 1'b1; r1_which_rdwr = RD; r1_addr = 16'h0020;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("tie%0d_req", k), {31'b0, mem_req_rdwr}, 32'd1);
            chk($sformatf("tie%0d_addr", k), {16'b0, mem_addr}, (k % 2 == 0) ? 32'h0010 : 32'h0020);
            step();
            chk($sformatf("tie%0d_wait", k), {29'b0, mem_req_rdwr, r1_ack, r0_ack}, 32'd0);
            step();
            if (k == 3) begin
                r0_req_rdwr = 1'b0; r1_req_rdwr = 1'b0;
            end
            chk($sformatf("tie%0d_ack", k), {29'b0, mem_req_rdwr, r1_ack, r0_ack},
                (k % 2 == 0) ? 32'd1 : 32'd2);
            step();
            chk($sformatf("tie%0d_idle", k), {29'b0, mem_req_rdwr, r1_ack, r0_ack}, 32'd0);
        end
        chk("tie_data", {16'b0, r1_data_in, r0_data_in}, 32'h2211);

        // Latched inputs: address change during ACCESS is ignored
        r0_req_rdwr = 1'b1; r0_which_rdwr = RD; r0_addr = 16'hf000;
        step();
        chk("latch_addr_acc", {16'b0, mem_addr}, 32'hf000);
        r0_addr = 16'h1234; r0_req_rdwr = 1'b0; r0_which_rdwr = WR;
        step();
        chk("latch_addr_wait", {16'b0, mem_addr}, 32'hf000);
        chk("latch_which_wait", {31'b0, mem_which_rdwr}, {31'b0, RD});
        step();
        chk("latch_ack", {30'b0, r1_ack, r0_ack}, 32'd1);
        chk("latch_data", {24'b0, r0_data_in}, 32'h45);
        step();

        // Reset asserted during WAIT abandons the access
        r0_req_rdwr = 1'b1; r0_which_rdwr = RD; r0_addr = 16'hf500;
        step();
        r0_req_rdwr = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw_mem_req", {31'b0, mem_req_rdwr}, 32'd0);
        chk("rstw_mem_addr", {16'b0, mem_addr}, 32'h0);
        chk("rstw_acks", {30'b0, r1_ack, r0_ack}, 32'd0);
        chk("rstw_data", {16'b0, r1_data_in, r0_data_in}, 32'h0);
        step();
        chk("rstw_no_late_ack", {30'b0, r1_ack, r0_ack}, 32'd0);
        r0_req_rdwr = 1'b1; r0_addr = 16'h0010;
        r1_req_rdwr = 1'b1; r1_addr = 16'h0020;
        step();
        r0_req_rdwr = 1'b0; r1_req_rdwr = 1'b0;
        chk("rstw_tie_addr", {16'b0, mem_addr}, 32'h0010);
        step(); step();
        chk("rstw_tie_ack", {30'b0, r1_ack, r0_ack}, 32'd1);
        step();

        // No requests for 20 clocks
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("idle%0d", i), {29'b0, mem_req_rdwr, r1_ack, r0_ack}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
